// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one 8N1 UART transmitter from NUM_REQ byte requesters.
// Bit timing is taken from the external oversample tick; there is no divider here.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  localparam int GID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick_16x,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [GID_W-1:0]     grant_id
);

  localparam int STOP_TICKS = OVERSAMPLE * STOP_BITS;
  localparam int TICK_W     = $clog2(STOP_TICKS + 1);

  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_TICKS - 1);
  localparam logic [GID_W-1:0]  LAST_ID   = GID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [GID_W-1:0]    rr_q, rr_d;
  logic [GID_W-1:0]    grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;

  // Arbitration: lowest valid index at or above rr_q, else lowest valid overall (wrap).
  logic [NUM_REQ-1:0]  at_or_above;
  logic [NUM_REQ-1:0]  masked_valid;
  logic [NUM_REQ-1:0]  pick_vec;
  logic [NUM_REQ-1:0]  lower_set;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [GID_W-1:0]    enc_chain  [NUM_REQ+1];
  logic [7:0]          data_chain [NUM_REQ+1];
  logic                any_valid;
  logic [GID_W-1:0]    winner;
  logic [7:0]          winner_data;
  logic [GID_W-1:0]    rr_after_win;

  assign enc_chain[0]  = '0;
  assign data_chain[0] = 8'h00;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_arb
    assign at_or_above[gi]  = (GID_W'(gi) >= rr_q);
    assign masked_valid[gi] = req_valid[gi] & at_or_above[gi];
    assign grant_oh[gi]     = pick_vec[gi] & ~lower_set[gi];
    assign enc_chain[gi+1]  = enc_chain[gi] | (grant_oh[gi] ? GID_W'(gi) : '0);
    assign data_chain[gi+1] = data_chain[gi] | (grant_oh[gi] ? req_data[8*gi +: 8] : 8'h00);
    if (gi == 0) begin : g_first
      assign lower_set[gi] = 1'b0;
    end else begin : g_rest
      assign lower_set[gi] = lower_set[gi-1] | pick_vec[gi-1];
    end
  end

  assign pick_vec     = (|masked_valid) ? masked_valid : req_valid;
  assign any_valid    = |req_valid;
  assign winner       = enc_chain[NUM_REQ];
  assign winner_data  = data_chain[NUM_REQ];
  assign rr_after_win = (winner == LAST_ID) ? '0 : winner + 1'b1;

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rr_d        = rr_q;
    grant_id_d  = grant_id_q;
    req_ready_d = '0;
    tx_d        = tx_q;
    busy_d      = busy_q;

    case (state_q)
      S_IDLE: begin
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        // Acceptance does not wait for a tick; the start bit begins on the next edge.
        if (any_valid) begin
          req_ready_d = grant_oh;
          shift_d     = winner_data;
          grant_id_d  = winner;
          rr_d        = rr_after_win;
          state_d     = S_START;
          tx_d        = 1'b0;
          busy_d      = 1'b1;
        end
      end

      S_START: begin
        if (tick_16x) begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d = '0;
            state_d    = S_DATA;
            tx_d       = shift_q[0];
            shift_d    = shift_q >> 1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (tick_16x) begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d = '0;
            if (bit_cnt_q == 3'd7) begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              tx_d      = shift_q[0];
              shift_d   = shift_q >> 1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (tick_16x) begin
          if (tick_cnt_q == STOP_LAST) begin
            tick_cnt_d = '0;
            state_d    = S_IDLE;
            busy_d     = 1'b0;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rr_q        <= '0;
      grant_id_q  <= '0;
      req_ready_q <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rr_q        <= rr_d;
      grant_id_q  <= grant_id_d;
      req_ready_q <= req_ready_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with one stop bit, one with two.
// The tick arrives every 4 clks, so one bit period is 64 clks.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick_16x = 1'b0;
  bit          tick_en = 1'b1;

  logic [1:0]  req_valid = 2'b00;
  logic [15:0] req_data = 16'h0000;
  logic [1:0]  req_ready;
  logic        tx;
  logic        busy;
  logic [0:0]  grant_id;

  logic [1:0]  req_valid2 = 2'b00;
  logic [15:0] req_data2 = 16'h0000;
  logic [1:0]  req_ready2;
  logic        tx2;
  logic        busy2;
  logic [0:0]  grant_id2;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_cnt0 = 0;
  int rdy_cnt1 = 0;
  int rdy2_cnt = 0;

  uart_tx_arbiter #(.NUM_REQ(2), .OVERSAMPLE(16), .STOP_BITS(1)) dut (
    .clk(clk), .reset_n(reset_n), .tick_16x(tick_16x),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx(tx), .busy(busy), .grant_id(grant_id)
  );

  uart_tx_arbiter #(.NUM_REQ(2), .OVERSAMPLE(16), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .tick_16x(tick_16x),
    .req_valid(req_valid2), .req_data(req_data2), .req_ready(req_ready2),
    .tx(tx2), .busy(busy2), .grant_id(grant_id2)
  );

  initial forever #5 clk = ~clk;

  // One-clk tick every fourth clk, changed just after the rising edge.
  initial begin : tick_gen
    int phase;
    phase = 0;
    forever begin
      @(posedge clk);
      #1;
      tick_16x = tick_en && (phase == 0);
      phase = (phase + 1) % 4;
    end
  end

  initial forever begin
    @(negedge clk);
    if (req_ready[0]) rdy_cnt0++;
    if (req_ready[1]) rdy_cnt1++;
    if (req_ready2 != 2'b00) rdy2_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    req_valid = 2'b00;
    req_valid2 = 2'b00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ready(input int max_clks, output int idx);
    idx = -1;
    for (int i = 0; i < max_clks && idx < 0; i++) begin
      @(negedge clk);
      if (req_ready[0]) idx = 0;
      else if (req_ready[1]) idx = 1;
    end
  endtask

  // Called one clk after the accept; samples each bit near its middle.
  task automatic rx_frame(output logic [7:0] b, output logic start_mid, output logic stop_bit);
    repeat (32) @(negedge clk);
    start_mid = tx;
    for (int k = 0; k < 8; k++) begin
      repeat (64) @(negedge clk);
      b[k] = tx;
    end
    repeat (64) @(negedge clk);
    stop_bit = tx;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = 2'b01;
    req_data = 16'h0055;
    repeat (3) @(negedge clk);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b, expected 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b, expected 00", req_ready); end
    n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %b, expected 0", grant_id); end
    n_checks++; if (tx2 !== 1'b1 || busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_dut2: got tx=%b busy=%b, expected tx=1 busy=0", tx2, busy2); end
    req_valid = 2'b00;
    reset_n = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_single_frame();
    int idx, c0, w;
    logic [7:0] b;
    logic sm, sp;
    apply_reset();
    c0 = rdy_cnt0;
    req_data = 16'h0055;
    req_valid = 2'b01;
    wait_ready(20, idx);
    n_checks++; if (idx !== 0) begin n_fail++; $display("FAIL single_idx: got %0d, expected 0", idx); end
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b, expected 01", req_ready); end
    n_checks++; if (tx !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_start: got tx=%b busy=%b, expected tx=0 busy=1", tx, busy); end
    req_valid = 2'b00;
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL single_pulse_width: got %b, expected 00", req_ready); end
    rx_frame(b, sm, sp);
    n_checks++; if (sm !== 1'b0) begin n_fail++; $display("FAIL single_startbit: got %b, expected 0", sm); end
    n_checks++; if (b !== 8'h55) begin n_fail++; $display("FAIL single_byte: got %h, expected 55", b); end
    n_checks++; if (sp !== 1'b1) begin n_fail++; $display("FAIL single_stopbit: got %b, expected 1", sp); end
    w = 0;
    while (busy && w < 64) begin @(negedge clk); w++; end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b, expected 0", busy); end
    repeat (100) @(negedge clk);
    n_checks++; if (rdy_cnt0 - c0 !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d, expected 1", rdy_cnt0 - c0); end
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_idle_tx: got %b, expected 1", tx); end
    $display("test_single_frame byte=%h", b);
  endtask

  task automatic test_back_to_back();
    int idx, c0, c1, exp_id;
    logic [7:0] b, exp_b;
    logic sm, sp;
    apply_reset();
    c0 = rdy_cnt0;
    c1 = rdy_cnt1;
    req_data = {8'h3C, 8'hA5};
    req_valid = 2'b11;
    for (int f = 0; f < 4; f++) begin
      exp_id = f % 2;
      exp_b = (exp_id == 1) ? 8'h3C : 8'hA5;
      wait_ready(200, idx);
      n_checks++; if (idx !== exp_id) begin n_fail++; $display("FAIL b2b_idx[%0d]: got %0d, expected %0d", f, idx, exp_id); end
      n_checks++; if (grant_id !== exp_id[0]) begin n_fail++; $display("FAIL b2b_grant[%0d]: got %b, expected %0d", f, grant_id, exp_id); end
      n_checks++; if ($countones(req_ready) !== 1) begin n_fail++; $display("FAIL b2b_onehot[%0d]: got %b, expected one bit", f, req_ready); end
      if (f == 3) req_valid = 2'b00;
      @(negedge clk);
      rx_frame(b, sm, sp);
      n_checks++; if (b !== exp_b || sp !== 1'b1) begin n_fail++; $display("FAIL b2b_byte[%0d]: got %h stop=%b, expected %h stop=1", f, b, sp, exp_b); end
      $display("test_back_to_back frame %0d grant=%0d byte=%h", f, idx, b);
    end
    repeat (200) @(negedge clk);
    n_checks++; if (rdy_cnt0 - c0 !== 2 || rdy_cnt1 - c1 !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d/%0d, expected 2/2", rdy_cnt0 - c0, rdy_cnt1 - c1); end
  endtask

  task automatic test_mid_frame_request();
    int idx, c1, w;
    logic [7:0] b;
    logic sm, sp;
    apply_reset();
    req_data = 16'h0012;
    req_valid = 2'b01;
    wait_ready(20, idx);
    n_checks++; if (idx !== 0) begin n_fail++; $display("FAIL mid_first_idx: got %0d, expected 0", idx); end
    req_valid = 2'b00;
    repeat (200) @(negedge clk);
    c1 = rdy_cnt1;
    req_data = 16'h9C12;
    req_valid = 2'b10;
    w = 0;
    while (busy && w < 700) begin @(negedge clk); w++; end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_end: got %b, expected 0", busy); end
    n_checks++; if (req_ready !== 2'b00 || rdy_cnt1 - c1 !== 0) begin n_fail++; $display("FAIL mid_early_ready: got %b count=%0d, expected 00 count=0", req_ready, rdy_cnt1 - c1); end
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL mid_ready1: got %b, expected 10", req_ready); end
    n_checks++; if (grant_id !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_grant: got grant=%b busy=%b, expected grant=1 busy=1", grant_id, busy); end
    req_valid = 2'b00;
    @(negedge clk);
    rx_frame(b, sm, sp);
    n_checks++; if (b !== 8'h9C) begin n_fail++; $display("FAIL mid_byte: got %h, expected 9c", b); end
    $display("test_mid_frame_request byte=%h", b);
  endtask

  task automatic test_two_stop_bits();
    int t, lowlen, busylen, late_low, c2;
    bit seen, rose;
    apply_reset();
    c2 = rdy2_cnt;
    req_data2 = 16'h00FF;
    req_valid2 = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (req_ready2[0]) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL stop2_ready: got %b, expected 1", seen); end
    n_checks++; if (tx2 !== 1'b0 || busy2 !== 1'b1 || grant_id2 !== 1'b0) begin n_fail++; $display("FAIL stop2_start: got tx=%b busy=%b grant=%b, expected 0 1 0", tx2, busy2, grant_id2); end
    req_valid2 = 2'b00;
    lowlen = 0; busylen = 0; late_low = 0; rose = 1'b0; t = 0;
    while (busy2 && t < 1000) begin
      busylen++;
      if (!tx2) begin
        lowlen++;
        if (rose) late_low++;
      end else begin
        rose = 1'b1;
      end
      @(negedge clk);
      t++;
    end
    n_checks++; if (!(lowlen >= 61 && lowlen <= 64)) begin n_fail++; $display("FAIL stop2_lowlen: got %0d clks, expected 61..64", lowlen); end
    n_checks++; if (busylen !== lowlen + 640) begin n_fail++; $display("FAIL stop2_busylen: got %0d clks, expected %0d", busylen, lowlen + 640); end
    n_checks++; if (late_low !== 0) begin n_fail++; $display("FAIL stop2_high: got %0d low clks after start, expected 0", late_low); end
    repeat (50) @(negedge clk);
    n_checks++; if (tx2 !== 1'b1 || busy2 !== 1'b0 || rdy2_cnt - c2 !== 1) begin n_fail++; $display("FAIL stop2_idle: got tx=%b busy=%b pulses=%0d, expected 1 0 1", tx2, busy2, rdy2_cnt - c2); end
    $display("test_two_stop_bits low=%0d busy=%0d", lowlen, busylen);
  endtask

  task automatic test_reset_mid_data();
    int idx, lows, c0, c1;
    logic [7:0] b;
    logic sm, sp;
    apply_reset();
    req_data = 16'h00F0;
    req_valid = 2'b01;
    wait_ready(20, idx);
    n_checks++; if (idx !== 0) begin n_fail++; $display("FAIL rst_first_idx: got %0d, expected 0", idx); end
    req_valid = 2'b00;
    repeat (288) @(negedge clk);
    n_checks++; if (tx !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL rst_bit3: got tx=%b busy=%b, expected 0 1", tx, busy); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1 || busy !== 1'b0 || req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_async: got tx=%b busy=%b ready=%b, expected 1 0 00", tx, busy, req_ready); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    c0 = rdy_cnt0;
    c1 = rdy_cnt1;
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    n_checks++; if (lows !== 0 || busy !== 1'b0 || rdy_cnt0 - c0 + rdy_cnt1 - c1 !== 0) begin n_fail++; $display("FAIL rst_idle: got lows=%0d busy=%b pulses=%0d, expected 0 0 0", lows, busy, rdy_cnt0 - c0 + rdy_cnt1 - c1); end
    req_data = 16'h3A00;
    req_valid = 2'b10;
    wait_ready(20, idx);
    n_checks++; if (idx !== 1 || grant_id !== 1'b1) begin n_fail++; $display("FAIL rst_winner: got idx=%0d grant=%b, expected 1 1", idx, grant_id); end
    req_valid = 2'b00;
    @(negedge clk);
    rx_frame(b, sm, sp);
    n_checks++; if (b !== 8'h3A) begin n_fail++; $display("FAIL rst_byte: got %h, expected 3a", b); end
    $display("test_reset_mid_data winner=%0d byte=%h", idx, b);
  endtask

  task automatic test_tick_stall();
    int idx, t, rises, w;
    apply_reset();
    req_data = 16'h0081;
    req_valid = 2'b01;
    wait_ready(20, idx);
    n_checks++; if (idx !== 0) begin n_fail++; $display("FAIL stall_idx: got %0d, expected 0", idx); end
    req_valid = 2'b00;
    t = 0;
    if (tick_16x) t++;
    repeat (8) begin
      @(negedge clk);
      if (tick_16x) t++;
    end
    tick_en = 1'b0;
    rises = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx) rises++;
      if (tick_16x) t++;
    end
    n_checks++; if (rises !== 0 || tx !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got rises=%0d tx=%b busy=%b, expected 0 0 1", rises, tx, busy); end
    tick_en = 1'b1;
    w = 0;
    while (!tx && w < 200) begin
      if (tick_16x) t++;
      @(negedge clk);
      w++;
    end
    n_checks++; if (t !== 16 || tx !== 1'b1) begin n_fail++; $display("FAIL stall_ticks: got %0d ticks tx=%b, expected 16 ticks tx=1", t, tx); end
    w = 0;
    while (busy && w < 700) begin @(negedge clk); w++; end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_busy_end: got %b, expected 0", busy); end
    $display("test_tick_stall start_ticks=%0d", t);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_mid_frame_request();
    test_two_stop_bits();
    test_reset_mid_data();
    test_tick_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
